reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Owns the single write port of the 8x8 register file.
- Arbitrates between requester 0 (ALU writeback) and requester 1 (data-memory load writeback), with round-robin fairness.
- Drives the register file's IN, INADDRESS and WRITE from registered outputs.
- Keeps a busy scoreboard of registers with an outstanding load, so decode can stall.

Parameters:
- DATA_WIDTH, 8, register data width
- ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH

Ports:
- CLK  input  1  clock, all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- REQ0  input  1  requester 0 write request
- ADDR0  input  ADDR_WIDTH  requester 0 destination register
- DATA0  input  DATA_WIDTH  requester 0 write data
- GNT0  output  1  requester 0 grant, one-cycle pulse
- REQ1 / ADDR1 / DATA1 / GNT1  as above, for requester 1 (load path)
- RESERVE_EN  input  1  load issued; mark RESERVE_ADDR busy
- RESERVE_ADDR  input  ADDR_WIDTH  destination of issued load
- CHK_ADDR1, CHK_ADDR2  input  ADDR_WIDTH  source registers of the decoding instruction
- STALL  output  1  a checked source is busy
- BUSY  output  NUM_REGS  scoreboard bits
- RF_IN  output  DATA_WIDTH  to register file IN
- RF_INADDRESS  output  ADDR_WIDTH  to register file INADDRESS
- RF_WRITE  output  1  to register file WRITE

Behaviour:
- Reset: asynchronous and active-high.
  - RF_IN=0, RF_INADDRESS=0, RF_WRITE=0, GNT0=GNT1=0, BUSY=0.
  - Round-robin pointer LAST=1, so requester 0 wins the first tie.
  - Reset mid-operation drops any in-flight grant and write. Requesters must re-request.
- Requester rules:
  - Hold REQx/ADDRx/DATAx stable until GNTx is seen high.
  - A requester whose GNTx is currently high is ineligible at that edge, so a held REQ is not double-granted.
- Arbitration at each posedge over eligible requests:
  - None eligible: RF_WRITE<=0, GNT0/1<=0; RF_IN and RF_INADDRESS hold.
  - One eligible: that requester wins.
  - Both eligible: the requester != LAST wins.
  - Winner w: GNTw<=1, other GNT<=0, RF_IN<=DATAw, RF_INADDRESS<=ADDRw, RF_WRITE<=1, LAST<=w.
- Latency:
  - REQ sampled at edge N; GNT and RF_WRITE high during cycle N+1.
  - Register file commits at edge N+1. Data is readable from the register file after its read delay.
- Throughput:
  - One write per cycle overall.
  - A single requester holding REQ continuously gets at most one grant every 2 cycles.
  - Both requesters continuously requesting alternate 0,1,0,1.
- Scoreboard, at each posedge:
  - RESERVE_EN sets BUSY[RESERVE_ADDR].
  - A grant to requester 1 clears BUSY[ADDR1].
  - Set and clear of the same address at the same edge: set wins (newer load).
  - RESERVE_EN on an already-busy register: stays busy.
  - Requester 0 grants never touch BUSY.
- STALL is combinational: BUSY[CHK_ADDR1] | BUSY[CHK_ADDR2]. It uses registered BUSY only.
- Address 0 gets no special treatment.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: requester 1 always wins when both are eligible; the LAST register is removed.
  - The ineligible-while-granted rule still applies, so requester 0 is served at least every other cycle.
- Undefined: round-robin as specified above.

Test Plan:
- Reset check: assert RESET asynchronously mid-cycle -> RF_WRITE, GNT0, GNT1, BUSY all 0 immediately. With both REQ high after release, the first grant goes to requester 0.
- Single write: REQ0=1, ADDR0=3, DATA0=0x5A for one sampled edge -> next cycle GNT0=1, RF_WRITE=1, RF_INADDRESS=3, RF_IN=0x5A. The following cycle RF_WRITE=0.
- Contention: REQ0 (ADDR 1, 0x11) and REQ1 (ADDR 2, 0x22) both held for 4 edges -> grant order 0,1,0,1 with matching RF outputs.
  - With WB_FIXED_PRIO_EN defined -> order 1,0,1,0.
- Scoreboard: RESERVE_EN=1, RESERVE_ADDR=5 -> BUSY=0x20. CHK_ADDR1=5 -> STALL=1. Grant requester 1 with ADDR1=5 -> BUSY=0x00, STALL=0.
- Set/clear collision: at the same edge, RESERVE_ADDR=4 with RESERVE_EN=1, and requester 1 granted with ADDR1=4 -> BUSY[4] remains 1.
- Held request: REQ1 held high for 5 edges -> GNT1 pattern 1,0,1,0,1. RF_WRITE is never high two consecutive cycles for requester 1 alone.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU and load writeback, plus load scoreboard.
// Define WB_FIXED_PRIO_EN to give requester 1 fixed priority on ties instead of round-robin.
module reg_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       REQ0,
    input  logic [ADDR_WIDTH-1:0]      ADDR0,
    input  logic [DATA_WIDTH-1:0]      DATA0,
    output logic                       GNT0,
    input  logic                       REQ1,
    input  logic [ADDR_WIDTH-1:0]      ADDR1,
    input  logic [DATA_WIDTH-1:0]      DATA1,
    output logic                       GNT1,
    input  logic                       RESERVE_EN,
    input  logic [ADDR_WIDTH-1:0]      RESERVE_ADDR,
    input  logic [ADDR_WIDTH-1:0]      CHK_ADDR1,
    input  logic [ADDR_WIDTH-1:0]      CHK_ADDR2,
    output logic                       STALL,
    output logic [(2**ADDR_WIDTH)-1:0] BUSY,
    output logic [DATA_WIDTH-1:0]      RF_IN,
    output logic [ADDR_WIDTH-1:0]      RF_INADDRESS,
    output logic                       RF_WRITE
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_rf_write;
    logic [DATA_WIDTH-1:0] r_rf_in;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic [NUM_REGS-1:0]   r_busy;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_win0;
    logic                  w_win1;
    logic                  w_gnt0_next;
    logic                  w_gnt1_next;
    logic                  w_rf_write_next;
    logic [DATA_WIDTH-1:0] w_rf_in_next;
    logic [ADDR_WIDTH-1:0] w_rf_addr_next;
    logic [NUM_REGS-1:0]   w_busy_next;

    // A requester whose grant is showing this cycle is still holding its old request.
    assign w_elig0 = REQ0 & ~r_gnt0;
    assign w_elig1 = REQ1 & ~r_gnt1;

`ifdef WB_FIXED_PRIO_EN
    assign w_win1 = w_elig1;
`else
    logic r_last;
    logic w_last_next;

    assign w_win1 = w_elig1 & (~w_elig0 | ~r_last);

    always_comb begin
        w_last_next = r_last;
        if (w_win0) begin
            w_last_next = 1'b0;
        end else if (w_win1) begin
            w_last_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_last <= 1'b1;
        end else begin
            r_last <= w_last_next;
        end
    end
`endif

    assign w_win0 = w_elig0 & ~w_win1;

    always_comb begin
        w_gnt0_next     = w_win0;
        w_gnt1_next     = w_win1;
        w_rf_write_next = w_win0 | w_win1;
        w_rf_in_next    = r_rf_in;
        w_rf_addr_next  = r_rf_addr;
        if (w_win0) begin
            w_rf_in_next   = DATA0;
            w_rf_addr_next = ADDR0;
        end else if (w_win1) begin
            w_rf_in_next   = DATA1;
            w_rf_addr_next = ADDR1;
        end
    end

    // Set is applied after clear so a newly issued load to the same register stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_win1) begin
            w_busy_next[ADDR1] = 1'b0;
        end
        if (RESERVE_EN) begin
            w_busy_next[RESERVE_ADDR] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rf_write <= 1'b0;
            r_rf_in    <= '0;
            r_rf_addr  <= '0;
            r_busy     <= '0;
        end else begin
            r_gnt0     <= w_gnt0_next;
            r_gnt1     <= w_gnt1_next;
            r_rf_write <= w_rf_write_next;
            r_rf_in    <= w_rf_in_next;
            r_rf_addr  <= w_rf_addr_next;
            r_busy     <= w_busy_next;
        end
    end

    assign GNT0         = r_gnt0;
    assign GNT1         = r_gnt1;
    assign RF_WRITE     = r_rf_write;
    assign RF_IN        = r_rf_in;
    assign RF_INADDRESS = r_rf_addr;
    assign BUSY         = r_busy;
    assign STALL        = r_busy[CHK_ADDR1] | r_busy[CHK_ADDR2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Honours WB_FIXED_PRIO_EN for the expected tie-break order.
module tb_reg_wb_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          REQ0 = 1'b0;
    logic [AW-1:0] ADDR0 = '0;
    logic [DW-1:0] DATA0 = '0;
    logic          GNT0;
    logic          REQ1 = 1'b0;
    logic [AW-1:0] ADDR1 = '0;
    logic [DW-1:0] DATA1 = '0;
    logic          GNT1;
    logic          RESERVE_EN = 1'b0;
    logic [AW-1:0] RESERVE_ADDR = '0;
    logic [AW-1:0] CHK_ADDR1 = '0;
    logic [AW-1:0] CHK_ADDR2 = '0;
    logic          STALL;
    logic [NR-1:0] BUSY;
    logic [DW-1:0] RF_IN;
    logic [AW-1:0] RF_INADDRESS;
    logic          RF_WRITE;

    reg_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ0         (REQ0),
        .ADDR0        (ADDR0),
        .DATA0        (DATA0),
        .GNT0         (GNT0),
        .REQ1         (REQ1),
        .ADDR1        (ADDR1),
        .DATA1        (DATA1),
        .GNT1         (GNT1),
        .RESERVE_EN   (RESERVE_EN),
        .RESERVE_ADDR (RESERVE_ADDR),
        .CHK_ADDR1    (CHK_ADDR1),
        .CHK_ADDR2    (CHK_ADDR2),
        .STALL        (STALL),
        .BUSY         (BUSY),
        .RF_IN        (RF_IN),
        .RF_INADDRESS (RF_INADDRESS),
        .RF_WRITE     (RF_WRITE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model state: who was granted last cycle, who won the last tie, pending loads.
    int m_granted;      // -1 none, else requester index
    int m_last_winner;
    bit m_pending [NR];
    int m_rf_data;
    int m_rf_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] model_busy();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_pending[i];
        return v;
    endfunction

    task automatic model_reset();
        m_granted = -1;
        m_last_winner = 1;
        for (int i = 0; i < NR; i++) m_pending[i] = 1'b0;
        m_rf_data = 0;
        m_rf_addr = 0;
    endtask

    task automatic model_edge();
        bit want0, want1;
        int winner;
        want0 = REQ0 && (m_granted != 0);
        want1 = REQ1 && (m_granted != 1);
        winner = -1;
        if (want0 && want1) begin
`ifdef WB_FIXED_PRIO_EN
            winner = 1;
`else
            winner = 1 - m_last_winner;
`endif
        end else if (want0) begin
            winner = 0;
        end else if (want1) begin
            winner = 1;
        end
        if (winner == 0) begin
            m_rf_data = int'(DATA0);
            m_rf_addr = int'(ADDR0);
        end else if (winner == 1) begin
            m_rf_data = int'(DATA1);
            m_rf_addr = int'(ADDR1);
            m_pending[ADDR1] = 1'b0;
        end
        if (RESERVE_EN) m_pending[RESERVE_ADDR] = 1'b1;
        if (winner >= 0) m_last_winner = winner;
        m_granted = winner;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".gnt0"}, 32'(GNT0), 32'(m_granted == 0));
        check_eq({tag, ".gnt1"}, 32'(GNT1), 32'(m_granted == 1));
        check_eq({tag, ".write"}, 32'(RF_WRITE), 32'(m_granted >= 0));
        check_eq({tag, ".rf_in"}, 32'(RF_IN), 32'(m_rf_data));
        check_eq({tag, ".rf_addr"}, 32'(RF_INADDRESS), 32'(m_rf_addr));
        check_eq({tag, ".busy"}, 32'(BUSY), 32'(model_busy()));
        check_eq({tag, ".stall"}, 32'(STALL),
                 32'(m_pending[CHK_ADDR1] || m_pending[CHK_ADDR2]));
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Assert reset mid-cycle, check outputs clear before any edge, release mid-cycle.
    task automatic do_reset();
        #2;
        RESET = 1'b1;
        #1;
        check_eq("rst.write", 32'(RF_WRITE), 32'd0);
        check_eq("rst.gnt0", 32'(GNT0), 32'd0);
        check_eq("rst.gnt1", 32'(GNT1), 32'd0);
        check_eq("rst.busy", 32'(BUSY), 32'd0);
        model_reset();
        @(posedge CLK);
        #3;
        RESET = 1'b0;
    endtask

    task automatic idle_inputs();
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        RESERVE_EN = 1'b0;
    endtask

    int order [4];
    int expected_order [4];
    logic [4:0] held_pat;

    initial begin
        model_reset();
        RESET = 1'b1;
        #12;
        RESET = 1'b0;
        step("init");

        // Single write
        REQ0 = 1'b1; ADDR0 = 3'd3; DATA0 = 8'h5A;
        step("single");
        check_eq("single.gnt0", 32'(GNT0), 32'd1);
        check_eq("single.addr", 32'(RF_INADDRESS), 32'd3);
        check_eq("single.data", 32'(RF_IN), 32'h5A);
        REQ0 = 1'b0;
        step("single2");
        check_eq("single.write_off", 32'(RF_WRITE), 32'd0);

        // Reset mid-operation with a live grant, then contention from a fresh reset
        REQ0 = 1'b1; REQ1 = 1'b1;
        ADDR0 = 3'd1; DATA0 = 8'h11; ADDR1 = 3'd2; DATA1 = 8'h22;
        step("pre_rst");
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step("cont");
            order[i] = GNT1 ? 1 : (GNT0 ? 0 : -1);
            check_eq("cont.rf_in", 32'(RF_IN), GNT1 ? 32'h22 : 32'h11);
        end
`ifdef WB_FIXED_PRIO_EN
        expected_order = '{1, 0, 1, 0};
`else
        expected_order = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) check_eq("cont.order", 32'(order[i]), 32'(expected_order[i]));
        idle_inputs();
        step("cont_end");

        // Scoreboard set then clear via load grant
        RESERVE_EN = 1'b1; RESERVE_ADDR = 3'd5; CHK_ADDR1 = 3'd5; CHK_ADDR2 = 3'd0;
        step("sb_set");
        check_eq("sb.busy_set", 32'(BUSY), 32'h20);
        check_eq("sb.stall_set", 32'(STALL), 32'd1);
        RESERVE_EN = 1'b0; REQ1 = 1'b1; ADDR1 = 3'd5; DATA1 = 8'h77;
        step("sb_clr");
        check_eq("sb.busy_clr", 32'(BUSY), 32'h00);
        check_eq("sb.stall_clr", 32'(STALL), 32'd0);

        // Set and clear of the same register at one edge: stays busy
        REQ1 = 1'b0; RESERVE_EN = 1'b1; RESERVE_ADDR = 3'd4;
        step("col_pre");
        REQ1 = 1'b1; ADDR1 = 3'd4; DATA1 = 8'h44;
        step("col");
        check_eq("col.gnt1", 32'(GNT1), 32'd1);
        check_eq("col.busy4", 32'(BUSY[4]), 32'd1);
        idle_inputs();
        step("col_end");

        // Held request from requester 1 alone
        REQ1 = 1'b1; ADDR1 = 3'd6; DATA1 = 8'h66;
        for (int i = 0; i < 5; i++) begin
            step("held");
            held_pat[4-i] = GNT1;
        end
        check_eq("held.pattern", 32'(held_pat), 32'b10101);
        idle_inputs();
        step("held_end");

        // Randomized traffic; requesters hold their request until granted
        for (int n = 0; n < 400; n++) begin
            if (m_granted == 0 || !REQ0) begin
                REQ0 = ($urandom_range(0, 99) < 60);
                ADDR0 = AW'($urandom);
                DATA0 = DW'($urandom);
            end
            if (m_granted == 1 || !REQ1) begin
                REQ1 = ($urandom_range(0, 99) < 60);
                ADDR1 = AW'($urandom);
                DATA1 = DW'($urandom);
            end
            RESERVE_EN = ($urandom_range(0, 99) < 40);
            RESERVE_ADDR = AW'($urandom);
            CHK_ADDR1 = AW'($urandom);
            CHK_ADDR2 = AW'($urandom);
            if (n == 200) do_reset();
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
